rle_tx_scheduler: RTL and testbench
===================================

Name: rle_tx_scheduler

Overview:
Sequences the run-length encoder output onto the UART transmitter for one video frame at a time. Captures each VALUE-AMOUNT pair when the encoder signals completion and buffers it in a small FIFO. Serialises the frame as: sync header, value/count byte pairs, terminator pair. Sits between the RLE stage of the VGA capture path and the UART TX byte interface; back-pressures the pixel source when its FIFO fills.

Parameters:
DEPTH, 4, pair FIFO depth in entries; power of two, 2..16.
SYNC0, 8'hA5, first header byte.
SYNC1, 8'h5A, second header byte.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
i_frame_start  input  1  one-cycle pulse: new frame begins.
i_frame_end  input  1  one-cycle pulse: last pixel of frame delivered to RLE.
i_rle_ready  input  1  RLE completion level; a rising edge marks a new pair.
i_rle_val  input  8  RLE value; sampled on the i_rle_ready rising edge.
i_rle_count  input  8  RLE amount, 1..255; sampled with i_rle_val.
o_fifo_full  output  1  FIFO holds DEPTH pairs; pixel source must stall.
o_tx_data  output  8  byte to UART TX; stable while o_tx_start is high.
o_tx_start  output  1  one-cycle transmit request.
i_tx_busy  input  1  UART busy; rises the cycle after an accepted start.
o_busy  output  1  high in any state other than IDLE.
o_overflow  output  1  sticky: a pair was dropped because the FIFO was full.

Behaviour:
- Reset, synchronous on RST=1 at a CLK edge: o_tx_data=0, o_tx_start=0, o_busy=0, o_overflow=0, o_fifo_full=0; FIFO emptied; eof_pending=0; edge-detect register=0; FSM=IDLE. A reset mid-frame abandons the frame immediately; no terminator is sent.
- Capture:
  - rdy_q = i_rle_ready delayed one cycle; edge = i_rle_ready & ~rdy_q.
  - On edge while FSM != IDLE: push {val,count} if the FIFO is not full at the start of the cycle. Otherwise drop the pair and set o_overflow.
  - A pop in the same cycle does not free a slot for that cycle's push.
  - Edges in IDLE are discarded and do not set overflow.
- FIFO: circular buffer with clog2(DEPTH)-bit pointers plus an occupancy counter of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH. o_fifo_full is registered and equals (count==DEPTH).
- UART handshake:
  - Drive o_tx_start=1 for exactly one cycle, only in a cycle where i_tx_busy=0; o_tx_data is set in that same cycle.
  - Next state is WAIT. Skip the first WAIT cycle as a guard cycle, then remain in WAIT until i_tx_busy=0, then proceed to the return state.
- FSM states: IDLE, HDR0, HDR1, POP, VAL, CNT, TERM0, TERM1, [CSUM], WAIT.
  - IDLE: on i_frame_start go to HDR0. On entry, clear o_overflow and eof_pending, and empty the FIFO. i_frame_start in any other state is ignored.
  - HDR0 sends SYNC0; HDR1 sends SYNC1.
  - POP: if the FIFO is non-empty, pop the pair into hold registers and go to VAL. Else if eof_pending, go to TERM0. Else stay in POP.
  - VAL sends the held value; CNT sends the held count, then returns to POP.
  - TERM0 sends 8'h00; TERM1 sends 8'h00. Count 0 never occurs in data, so {00,00} marks end of frame.
  - After TERM1, go to IDLE (or to CSUM if enabled).
- i_frame_end: sets eof_pending in any non-IDLE state. The terminator is sent only after the FIFO drains and the current pair completes. A simultaneous capture edge and i_frame_end: the pair is pushed and is sent before the terminator.
- Latency: i_frame_start to first o_tx_start = 2 cycles when i_tx_busy=0. Each byte costs at least 1 start cycle, 1 guard cycle, and the UART busy time.

Optional Feature:
RLE_CHECKSUM_EN.
- Defined: an 8-bit XOR accumulator clears on frame start and XORs in every byte sent after the header, including both terminator bytes. State CSUM follows TERM1 and sends the accumulator, then the FSM goes to IDLE.
- Undefined: no accumulator and no CSUM state; TERM1 goes straight to IDLE.

Test Plan:
- Basic frame: frame_start, pairs {0x10,3},{0x80,255}, frame_end, UART busy 10 cycles per byte -> tx bytes A5,5A,10,03,80,FF,00,00; o_busy falls after the last byte; o_overflow=0.
- Overflow: DEPTH=4, hold i_tx_busy=1, present 6 rising edges -> o_fifo_full=1 after the 4th; pairs 5-6 dropped; o_overflow=1; after release, exactly 4 pairs are sent.
- Level vs edge: i_rle_ready held high for 20 cycles -> exactly one pair captured.
- Simultaneous: capture edge {0x33,7} and i_frame_end in the same cycle -> 33,07 sent before 00,00.
- Reset mid-frame: assert RST while the VAL byte is pending -> next cycle all outputs are 0 and FSM is IDLE; a new frame_start sends A5 first, with no stale pairs.
- Checksum (RLE_CHECKSUM_EN): pairs {0x10,3},{0x80,255} -> CSUM byte = 10^03^80^FF^00^00 = 0x6C.

Source files
------------

// File: rtl/rle_tx_scheduler.sv
// rtl/rle_tx_scheduler.sv - frames RLE value/count pairs onto a UART TX byte interface
// Optional RLE_CHECKSUM_EN appends an XOR checksum byte after the terminator pair.
module rle_tx_scheduler #(
    parameter int         DEPTH = 4,
    parameter logic [7:0] SYNC0 = 8'hA5,
    parameter logic [7:0] SYNC1 = 8'h5A
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_frame_start,
    input  logic       i_frame_end,
    input  logic       i_rle_ready,
    input  logic [7:0] i_rle_val,
    input  logic [7:0] i_rle_count,
    output logic       o_fifo_full,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    input  logic       i_tx_busy,
    output logic       o_busy,
    output logic       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_POP,
        S_VAL,
        S_CNT,
        S_TERM0,
        S_TERM1,
`ifdef RLE_CHECKSUM_EN
        S_CSUM,
`endif
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    state_t        r_ret;
    state_t        w_next_ret;
    logic          r_guard;

    logic          r_rdy_q;
    logic          w_edge;
    logic          w_push;
    logic          w_pop;
    logic          w_send;
    logic [7:0]    w_send_byte;
    logic          w_enter_idle;
    logic [CW-1:0] w_count_nxt;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic [7:0]    r_hold_val;
    logic [7:0]    r_hold_cnt;
    logic          r_eof;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic          r_tx_start;
`ifdef RLE_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    assign w_edge       = i_rle_ready & ~r_rdy_q;
    assign w_enter_idle = (r_state != S_IDLE) && (w_next == S_IDLE);
    // Full is judged on start-of-cycle state, so a same-cycle pop never makes room.
    assign w_push       = w_edge && (r_state != S_IDLE) && !r_full && !w_enter_idle;
    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

    assign o_fifo_full  = r_full;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = r_tx_start;
    assign o_busy       = (r_state != S_IDLE);
    assign o_overflow   = r_overflow;

    always_comb begin
        w_next      = r_state;
        w_next_ret  = r_ret;
        w_send      = 1'b0;
        w_send_byte = 8'h00;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_frame_start) w_next = S_HDR0;
            end
            S_HDR0: begin
                if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_send_byte = SYNC0;
                    w_next_ret  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_send_byte = SYNC1;
                    w_next_ret  = S_POP;
                end
            end
            S_POP: begin
                if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = S_VAL;
                end else if (r_eof) begin
                    w_next = S_TERM0;
                end
            end
            S_VAL: begin
                if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_send_byte = r_hold_val;
                    w_next_ret  = S_CNT;
                end
            end
            S_CNT: begin
                if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_send_byte = r_hold_cnt;
                    w_next_ret  = S_POP;
                end
            end
            S_TERM0: begin
                if (!i_tx_busy) begin
                    w_send     = 1'b1;
                    w_next_ret = S_TERM1;
                end
            end
            S_TERM1: begin
                if (!i_tx_busy) begin
                    w_send     = 1'b1;
`ifdef RLE_CHECKSUM_EN
                    w_next_ret = S_CSUM;
`else
                    w_next_ret = S_IDLE;
`endif
                end
            end
`ifdef RLE_CHECKSUM_EN
            S_CSUM: begin
                if (!i_tx_busy) begin
                    w_send      = 1'b1;
                    w_send_byte = r_csum;
                    w_next_ret  = S_IDLE;
                end
            end
`endif
            S_WAIT: begin
                // First WAIT cycle is a guard: the UART only raises busy a cycle after start.
                if (!r_guard && !i_tx_busy) w_next = r_ret;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_send) w_next = S_WAIT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ret      <= S_IDLE;
            r_guard    <= 1'b0;
            r_rdy_q    <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_ret      <= w_next_ret;
            r_guard    <= w_send;
            r_rdy_q    <= i_rle_ready;
            r_tx_start <= w_send;
            if (w_send) r_tx_data <= w_send_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {i_rle_val, i_rle_count};
    end

    always_ff @(posedge CLK) begin
        if (RST || w_enter_idle) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_val <= 8'h00;
            r_hold_cnt <= 8'h00;
        end else if (w_pop) begin
            r_hold_val <= r_mem[r_rd_ptr][15:8];
            r_hold_cnt <= r_mem[r_rd_ptr][7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || w_enter_idle) begin
            r_eof      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (i_frame_end && r_state != S_IDLE) r_eof <= 1'b1;
            if (w_edge && r_state != S_IDLE && r_full) r_overflow <= 1'b1;
        end
    end

`ifdef RLE_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_csum <= 8'h00;
        end else if (r_state == S_IDLE && i_frame_start) begin
            r_csum <= 8'h00;
        end else if (w_send && (r_state == S_VAL || r_state == S_CNT ||
                                r_state == S_TERM0 || r_state == S_TERM1)) begin
            r_csum <= r_csum ^ w_send_byte;
        end
    end
`endif

endmodule

// File: tb/tb_rle_tx_scheduler.sv
// tb/tb_rle_tx_scheduler.sv - directed and randomized frame bench for rle_tx_scheduler
module tb_rle_tx_scheduler;
    localparam int DEPTH = 4;
`ifdef RLE_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_frame_start = 1'b0;
    logic       i_frame_end = 1'b0;
    logic       i_rle_ready = 1'b0;
    logic [7:0] i_rle_val = 8'h00;
    logic [7:0] i_rle_count = 8'h00;
    logic       i_tx_busy = 1'b0;
    logic       o_fifo_full;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_overflow;

    rle_tx_scheduler #(.DEPTH(DEPTH), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
        .CLK(CLK), .RST(RST),
        .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
        .i_rle_ready(i_rle_ready), .i_rle_val(i_rle_val), .i_rle_count(i_rle_count),
        .o_fifo_full(o_fifo_full), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .i_tx_busy(i_tx_busy), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    logic [7:0] csum_m = 8'h00;
    int  uart_len = 10;
    int  busy_cnt = 0;
    bit  hold_busy = 0;
    bit  uart_busy = 0;
    bit  pend = 0;
    bit  ovf_allowed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // UART: busy rises the cycle after a start and stays high uart_len cycles.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) uart_busy = 0;
            end
            if (pend) begin
                uart_busy = 1;
                busy_cnt  = uart_len;
                pend      = 0;
            end
            if (o_tx_start) pend = 1;
            i_tx_busy = hold_busy | uart_busy;
        end
    end

    // Compare process: every transmitted byte against the expected byte stream.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && o_tx_start) begin
                got_q.push_back(o_tx_data);
                check("start_while_busy", {31'd0, i_tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_extra_byte: got %0h required no byte", o_tx_data);
                end else begin
                    check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (!ovf_allowed) check("overflow_clear", {31'd0, o_overflow}, 32'd0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_pair(input logic [7:0] v, input logic [7:0] c);
        exp_q.push_back(v);
        exp_q.push_back(c);
        csum_m = csum_m ^ v ^ c;
    endtask

    task automatic push_term();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
`ifdef RLE_CHECKSUM_EN
        exp_q.push_back(csum_m);
`endif
    endtask

    task automatic start_frame();
        got_q.delete();
        csum_m = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        i_frame_start = 1;
        tick();
        i_frame_start = 0;
    endtask

    task automatic end_frame();
        i_frame_end = 1;
        push_term();
        tick();
        i_frame_end = 0;
    endtask

    task automatic send_pair(input logic [7:0] v, input logic [7:0] c, input bit with_end,
                             input bit accept, input int hi, input int lo);
        i_rle_ready = 1;
        i_rle_val   = v;
        i_rle_count = c;
        i_frame_end = with_end;
        if (accept) push_pair(v, c);
        if (with_end) push_term();
        tick();
        i_frame_end = 0;
        tick(hi - 1);
        i_rle_ready = 0;
        tick(lo);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (o_busy && k < budget) begin
            tick();
            k++;
        end
        check(name, {31'd0, o_busy}, 32'd0);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic_exp [8];
        basic_exp = '{8'hA5, 8'h5A, 8'h10, 8'h03, 8'h80, 8'hFF, 8'h00, 8'h00};

        tick(3);
        RST = 0;
        check("rst_tx_data",  {24'd0, o_tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_busy",     {31'd0, o_busy}, 32'd0);
        check("rst_overflow", {31'd0, o_overflow}, 32'd0);
        check("rst_full",     {31'd0, o_fifo_full}, 32'd0);
        tick(2);

        // Basic frame with 10-cycle UART busy and start latency.
        uart_len = 10;
        start_frame();
        check("basic_busy_rise", {31'd0, o_busy}, 32'd1);
        check("basic_no_early_start", {31'd0, o_tx_start}, 32'd0);
        tick();
        check("basic_latency_start", {31'd0, o_tx_start}, 32'd1);
        check("basic_latency_data", {24'd0, o_tx_data}, 32'hA5);
        send_pair(8'h10, 8'd3, 0, 1, 1, 1);
        send_pair(8'h80, 8'd255, 0, 1, 1, 1);
        end_frame();
        wait_idle("basic_idle", 2000);
        check("basic_overflow", {31'd0, o_overflow}, 32'd0);
        check("basic_len", got_q.size(), 32'(8 + CS));
        for (int i = 0; i < 8; i++) check("basic_literal", {24'd0, got_q[i]}, {24'd0, basic_exp[i]});
`ifdef RLE_CHECKSUM_EN
        check("basic_csum", {24'd0, got_q[8]}, 32'h6C);
`endif

        // Overflow: UART held busy, six edges into a four-entry FIFO.
        uart_len = 3;
        hold_busy = 1;
        tick(2);
        ovf_allowed = 1;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            send_pair(8'(8'h20 + i), 8'(i + 1), 0, (i < DEPTH), 1, 1);
            if (i == DEPTH - 2) check("ovf_not_full_3", {31'd0, o_fifo_full}, 32'd0);
            if (i == DEPTH - 1) check("ovf_full_4", {31'd0, o_fifo_full}, 32'd1);
            if (i == DEPTH - 1) check("ovf_flag_4", {31'd0, o_overflow}, 32'd0);
        end
        check("ovf_flag", {31'd0, o_overflow}, 32'd1);
        check("ovf_full_6", {31'd0, o_fifo_full}, 32'd1);
        end_frame();
        hold_busy = 0;
        wait_idle("ovf_idle", 2000);
        check("ovf_len", got_q.size(), 32'(2 + 2 * DEPTH + 2 + CS));
        check("ovf_cleared_idle", {31'd0, o_overflow}, 32'd0);
        ovf_allowed = 0;
        tick(2);

        // Level vs edge: ready held high for 20 cycles.
        uart_len = 2;
        start_frame();
        i_rle_ready = 1;
        i_rle_val   = 8'h5C;
        i_rle_count = 8'd9;
        push_pair(8'h5C, 8'd9);
        tick(20);
        i_rle_ready = 0;
        tick();
        end_frame();
        wait_idle("level_idle", 2000);
        check("level_len", got_q.size(), 32'(6 + CS));

        // Capture edge and frame end in the same cycle.
        start_frame();
        send_pair(8'h33, 8'd7, 1, 1, 1, 1);
        wait_idle("simul_idle", 2000);
        check("simul_val",   {24'd0, got_q[2]}, 32'h33);
        check("simul_cnt",   {24'd0, got_q[3]}, 32'h07);
        check("simul_term0", {24'd0, got_q[4]}, 32'h00);
        check("simul_term1", {24'd0, got_q[5]}, 32'h00);

        // Reset while the VAL byte is pending.
        uart_len = 8;
        start_frame();
        send_pair(8'h44, 8'd2, 0, 1, 1, 1);
        begin
            int k = 0;
            while (got_q.size() < 2 && k < 500) begin
                tick();
                k++;
            end
            check("rstmid_hdr_sent", got_q.size(), 32'd2);
        end
        tick(2);
        RST = 1;
        tick();
        check("rstmid_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rstmid_tx_data",  {24'd0, o_tx_data}, 32'd0);
        check("rstmid_busy",     {31'd0, o_busy}, 32'd0);
        check("rstmid_overflow", {31'd0, o_overflow}, 32'd0);
        check("rstmid_full",     {31'd0, o_fifo_full}, 32'd0);
        RST = 0;
        exp_q.delete();
        tick(2);
        start_frame();
        end_frame();
        wait_idle("rstmid_idle", 2000);
        check("rstmid_len", got_q.size(), 32'(4 + CS));
        check("rstmid_first", {24'd0, got_q[0]}, 32'hA5);

        // Randomized frames; a pair is offered only when the FIFO reports space.
        for (int f = 0; f < 25; f++) begin
            int np;
            bit simul;
            uart_len = $urandom_range(1, 5);
            np    = $urandom_range(0, 9);
            simul = ($urandom_range(0, 1) == 1) && (np > 0);
            start_frame();
            for (int p = 0; p < np; p++) begin
                int k = 0;
                tick($urandom_range(0, 3));
                while (o_fifo_full && k < 2000) begin
                    tick();
                    k++;
                end
                if (o_fifo_full) check("rand_full_stuck", {31'd0, o_fifo_full}, 32'd0);
                send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                          simul && (p == np - 1), 1, $urandom_range(1, 3), $urandom_range(1, 2));
                if (p == 0 && $urandom_range(0, 3) == 0) begin
                    i_frame_start = 1;
                    tick();
                    i_frame_start = 0;
                end
            end
            if (!simul) begin
                tick($urandom_range(0, 3));
                end_frame();
            end
            wait_idle("rand_idle", 5000);
            check("rand_overflow", {31'd0, o_overflow}, 32'd0);
            tick($urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
